// File: rtl/uart_stream_bridge.sv
// Command-driven bridge from the sensor-data FIFO stream to the UART TX stream.
// Define UART_STREAM_CHECKSUM_EN to append an XOR checksum byte after each send/burst.
module uart_stream_bridge #(
    parameter int                DATA_W         = 8,
    parameter int                BURST_W        = 8,
    parameter logic [DATA_W-1:0] CMD_SEND       = 8'hA5,
    parameter logic [DATA_W-1:0] CMD_BURST      = 8'hB5,
    parameter logic [DATA_W-1:0] CMD_STATUS     = 8'hC5,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] PAD_BYTE       = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic [DATA_W-1:0] i_fifo_data,
    input  logic              i_fifo_valid,
    output logic              o_fifo_ready,
    input  logic              i_fifo_full,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_cmd_err
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BURST_W-1:0] CNT_ONE  = BURST_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_COUNT,
        ST_FETCH,
        ST_SEND,
        ST_STATUS
`ifdef UART_STREAM_CHECKSUM_EN
        , ST_CHKSUM
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 timeout_q, timeout_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 fifo_ready_q, fifo_ready_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
`ifdef UART_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0]    chk_q, chk_d;
`endif

    logic rx_fire;
    logic fifo_fire;
    logic tx_fire;

    // Status byte layout, MSB first: overflow, FIFO full, timeout, then zeros.
    function automatic logic [DATA_W-1:0] status_byte(input logic ovf, input logic full,
                                                      input logic tmo);
        logic [DATA_W-1:0] s;
        s             = '0;
        s[DATA_W-1]   = ovf;
        s[DATA_W-2]   = full;
        s[DATA_W-3]   = tmo;
        return s;
    endfunction

    assign rx_fire   = i_rx_valid & rx_ready_q;
    assign fifo_fire = i_fifo_valid & fifo_ready_q;
    assign tx_fire   = tx_valid_q & i_tx_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q | i_fifo_full;
        tx_data_d  = tx_data_q;
        cmd_err_d  = 1'b0;
`ifdef UART_STREAM_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (i_rx_data == CMD_SEND) begin
                        count_d = CNT_ONE;
                        timer_d = '0;
                        state_d = ST_FETCH;
`ifdef UART_STREAM_CHECKSUM_EN
                        chk_d   = '0;
`endif
                    end else if (i_rx_data == CMD_BURST) begin
                        state_d = ST_GET_COUNT;
`ifdef UART_STREAM_CHECKSUM_EN
                        chk_d   = '0;
`endif
                    end else if (i_rx_data == CMD_STATUS) begin
                        // Snapshot on entry so the byte stays stable while the UART stalls.
                        tx_data_d = status_byte(overflow_d, i_fifo_full, timeout_q);
                        state_d   = ST_STATUS;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_GET_COUNT: begin
                if (rx_fire) begin
                    count_d = i_rx_data[BURST_W-1:0];
                    if (i_rx_data[BURST_W-1:0] == '0) begin
`ifdef UART_STREAM_CHECKSUM_EN
                        tx_data_d = chk_q;
                        state_d   = ST_CHKSUM;
`else
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        timer_d = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fifo_fire) begin
                    tx_data_d = i_fifo_data;
                    timer_d   = '0;
                    state_d   = ST_SEND;
                end else if (timer_q == TMR_LAST) begin
                    tx_data_d = PAD_BYTE;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_SEND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_fire) begin
                    count_d = count_q - CNT_ONE;
`ifdef UART_STREAM_CHECKSUM_EN
                    chk_d   = chk_q ^ tx_data_q;
`endif
                    if (count_q == CNT_ONE) begin
`ifdef UART_STREAM_CHECKSUM_EN
                        tx_data_d = chk_q ^ tx_data_q;
                        state_d   = ST_CHKSUM;
`else
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_STATUS: begin
                if (tx_fire) begin
                    // A full flag in the clearing cycle re-arms overflow.
                    overflow_d = i_fifo_full;
                    timeout_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
`ifdef UART_STREAM_CHECKSUM_EN
            ST_CHKSUM: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered, decoded from the next state.
    always_comb begin
        rx_ready_d   = (state_d == ST_IDLE) || (state_d == ST_GET_COUNT);
        fifo_ready_d = (state_d == ST_FETCH);
        tx_valid_d   = (state_d == ST_SEND) || (state_d == ST_STATUS);
`ifdef UART_STREAM_CHECKSUM_EN
        if (state_d == ST_CHKSUM) begin
            tx_valid_d = 1'b1;
        end
`endif
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            tx_data_q    <= '0;
            cmd_err_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
            fifo_ready_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_STREAM_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            tx_data_q    <= tx_data_d;
            cmd_err_q    <= cmd_err_d;
            rx_ready_q   <= rx_ready_d;
            fifo_ready_q <= fifo_ready_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
`ifdef UART_STREAM_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign o_rx_ready   = rx_ready_q;
    assign o_fifo_ready = fifo_ready_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_busy       = busy_q;
    assign o_overflow   = overflow_q;
    assign o_cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: vector table, hand-written corner sequences and a
// randomized command stream checked against a queue-based model of the host protocol.
module tb_uart_stream_bridge;

    localparam int DW = 8;
    localparam int TO = 16;
`ifdef UART_STREAM_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic          o_rx_ready;
    logic [DW-1:0] i_fifo_data = '0;
    logic          i_fifo_valid = 1'b0;
    logic          o_fifo_ready;
    logic          i_fifo_full = 1'b0;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b0;
    logic          o_busy;
    logic          o_overflow;
    logic          o_cmd_err;

    always #5 clk = ~clk;

    uart_stream_bridge #(
        .DATA_W(DW), .BURST_W(8), .CMD_SEND(8'hA5), .CMD_BURST(8'hB5), .CMD_STATUS(8'hC5),
        .TIMEOUT_CYCLES(TO), .PAD_BYTE(8'h00)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .i_fifo_data(i_fifo_data), .i_fifo_valid(i_fifo_valid), .o_fifo_ready(o_fifo_ready),
        .i_fifo_full(i_fifo_full),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_overflow(o_overflow), .o_cmd_err(o_cmd_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] tx_log[$];
    int         tx_at[$];
    int         pop_at[$];
    int         sample  = 0;
    int         err_cyc = 0;
    int         pops    = 0;
    int         rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled
    bit         fifo_rand = 1'b0;
    bit         rx_rand   = 1'b0;
    int         fifo_low  = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  arg;
        bit          has_arg;
        int          nw;
        logic [31:0] words;
        int          ne;
        logic [31:0] expb;
        int          eerr;
        int          epops;
        int          mode;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bit gate;
        i_rx_valid = (rx_q.size() > 0) && (!rx_rand || ($urandom_range(0, 3) != 0));
        i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        gate = 1'b1;
        if (fifo_rand && fifo_low < 3 && $urandom_range(0, 3) == 0) begin
            gate = 1'b0;
            fifo_low++;
        end else begin
            fifo_low = 0;
        end
        i_fifo_valid = (fifo_q.size() > 0) && gate;
        i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        case (rdy_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = ~i_tx_ready;
            2:       i_tx_ready = 1'($urandom_range(0, 1));
            default: i_tx_ready = 1'b0;
        endcase
    endtask

    // One clock: note handshakes that will fire on the coming edge, advance, re-drive.
    task automatic tick();
        bit         rx_x, f_x, t_x, hold;
        logic [7:0] hold_data;
        rx_x = i_rx_valid && o_rx_ready;
        f_x  = i_fifo_valid && o_fifo_ready;
        t_x  = o_tx_valid && i_tx_ready;
        if (t_x) begin
            tx_log.push_back(o_tx_data);
            tx_at.push_back(sample);
        end
        if (f_x) begin
            pops++;
            pop_at.push_back(sample);
        end
        if (o_cmd_err) err_cyc++;
        hold      = o_tx_valid && !i_tx_ready;
        hold_data = o_tx_data;
        @(posedge clk);
        #1;
        sample++;
        if (hold) begin
            check("tx_hold_valid", o_tx_valid, 1);
            check("tx_hold_data", o_tx_data, hold_data);
        end
        if (rx_x) void'(rx_q.pop_front());
        if (f_x) void'(fifo_q.pop_front());
        drive();
    endtask

    task automatic run_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            tick();
            n++;
            if (rx_q.size() == 0 && !o_busy && !o_tx_valid) quiet++;
            else quiet = 0;
        end
        check("idle_reached", quiet >= 3, 1);
    endtask

    task automatic start_run();
        tx_log.delete();
        tx_at.delete();
        pop_at.delete();
        err_cyc = 0;
        pops    = 0;
    endtask

    task automatic compare_tx(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, tx_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (k < tx_log.size()) check($sformatf("%s_b%0d", name, k), tx_log[k], exp[k]);
        end
    endtask

    logic [7:0] exp_q[$];
    vec_t       vt[8];

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {o_rx_ready, o_fifo_ready, o_tx_data, o_tx_valid, o_busy, o_overflow, o_cmd_err}, 0);
        rst_n = 1'b1;
        drive();

        vt[0] = '{8'hA5, 8'h00, 1'b0, 1, 32'h0000003C, 1, 32'h0000003C, 0, 1, 0};
        vt[1] = '{8'hB5, 8'h04, 1'b1, 4, 32'h04030201, 4, 32'h04030201, 0, 4, 1};
        vt[2] = '{8'h7E, 8'h00, 1'b0, 1, 32'h00000099, 0, 32'h00000000, 1, 0, 0};
        vt[3] = '{8'hB5, 8'h00, 1'b1, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 0};
        vt[4] = '{8'hB5, 8'h02, 1'b1, 2, 32'h000055AA, 2, 32'h000055AA, 0, 2, 2};
        vt[5] = '{8'hC5, 8'h00, 1'b0, 0, 32'h00000000, 1, 32'h00000000, 0, 0, 0};
        vt[6] = '{8'h00, 8'h00, 1'b0, 0, 32'h00000000, 0, 32'h00000000, 1, 0, 0};
        vt[7] = '{8'hA5, 8'h00, 1'b0, 1, 32'h000000FF, 1, 32'h000000FF, 0, 1, 1};

        for (int i = 0; i < 8; i++) begin
            logic [7:0] x;
            start_run();
            fifo_q.delete();
            exp_q.delete();
            rdy_mode = vt[i].mode;
            for (int k = 0; k < vt[i].nw; k++) fifo_q.push_back(vt[i].words[8*k +: 8]);
            rx_q.push_back(vt[i].cmd);
            if (vt[i].has_arg) rx_q.push_back(vt[i].arg);
            x = 8'h00;
            for (int k = 0; k < vt[i].ne; k++) begin
                exp_q.push_back(vt[i].expb[8*k +: 8]);
                x ^= vt[i].expb[8*k +: 8];
            end
            if (CHK && (vt[i].cmd == 8'hA5 || vt[i].cmd == 8'hB5)) exp_q.push_back(x);
            drive();
            run_idle(500);
            compare_tx($sformatf("vec%0d_tx", i), exp_q);
            check($sformatf("vec%0d_cmd_err_cycles", i), err_cyc, vt[i].eerr);
            check($sformatf("vec%0d_fifo_pops", i), pops, vt[i].epops);
            if (vt[i].mode == 0) begin
                for (int k = 0; k < pop_at.size() && k < tx_at.size(); k++)
                    check($sformatf("vec%0d_pop_to_valid", i), tx_at[k] - pop_at[k], 1);
            end
        end
        fifo_q.delete();

        // Timeout padding: one word available for a 3-byte burst
        start_run();
        rdy_mode = 0;
        fifo_q.push_back(8'h11);
        rx_q.push_back(8'hB5);
        rx_q.push_back(8'h03);
        exp_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        if (CHK) exp_q.push_back(8'h11);
        drive();
        run_idle(500);
        compare_tx("timeout_tx", exp_q);
        check("timeout_pops", pops, 1);
        check("timeout_pad_seen", tx_at.size() >= 3, 1);
        if (tx_at.size() >= 3) begin
            check("pad1_delay", tx_at[1] - tx_at[0], TO + 1);
            check("pad2_delay", tx_at[2] - tx_at[1], TO + 1);
        end
        start_run();
        rx_q.push_back(8'hC5);
        drive();
        run_idle(200);
        exp_q.delete();
        exp_q.push_back(8'h20);
        compare_tx("status_after_timeout", exp_q);
        start_run();
        rx_q.push_back(8'hC5);
        drive();
        run_idle(200);
        exp_q.delete();
        exp_q.push_back(8'h00);
        compare_tx("status_cleared", exp_q);

        // Overflow: one-cycle full pulse is sticky until a status read
        i_fifo_full = 1'b1;
        tick();
        i_fifo_full = 1'b0;
        tick();
        check("overflow_sticky", o_overflow, 1);
        start_run();
        rx_q.push_back(8'hC5);
        drive();
        run_idle(200);
        exp_q.delete();
        exp_q.push_back(8'h80);
        compare_tx("status_overflow", exp_q);
        check("overflow_cleared", o_overflow, 0);
        start_run();
        rx_q.push_back(8'hC5);
        drive();
        run_idle(200);
        exp_q.delete();
        exp_q.push_back(8'h00);
        compare_tx("status_overflow_again", exp_q);

        // Reset while the second byte of a 4-byte burst is on the TX port
        start_run();
        rdy_mode = 0;
        for (int k = 1; k <= 4; k++) fifo_q.push_back(8'(k));
        rx_q.push_back(8'hB5);
        rx_q.push_back(8'h04);
        drive();
        for (int n = 0; n < 200 && tx_log.size() < 1; n++) tick();
        check("burst_first_byte", tx_log.size(), 1);
        rdy_mode = 3;
        i_tx_ready = 1'b0;
        repeat (3) tick();
        check("burst_second_valid", o_tx_valid, 1);
        check("burst_second_data", o_tx_data, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {o_rx_ready, o_fifo_ready, o_tx_data, o_tx_valid, o_busy, o_overflow, o_cmd_err}, 0);
        rx_q.delete();
        fifo_q.delete();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_run();
        rdy_mode = 0;
        fifo_q.push_back(8'h77);
        rx_q.push_back(8'hA5);
        drive();
        run_idle(300);
        exp_q.delete();
        exp_q.push_back(8'h77);
        if (CHK) exp_q.push_back(8'h77);
        compare_tx("after_reset_send", exp_q);
        check("after_reset_pops", pops, 1);

        // Randomized command stream against the protocol model
        begin
            int  exp_err = 0;
            int  exp_pops = 0;
            bit  ov = 1'b0;
            bit  tmo = 1'b0;
            start_run();
            exp_q.delete();
            rdy_mode  = 2;
            fifo_rand = 1'b1;
            rx_rand   = 1'b1;
            for (int c = 0; c < 150; c++) begin
                int         kind;
                int         n;
                logic [7:0] b;
                logic [7:0] w;
                logic [7:0] x;
                kind = $urandom_range(0, 3);
                n = 0;
                if (kind == 0) begin
                    rx_q.push_back(8'hA5);
                    n = 1;
                end else if (kind == 1) begin
                    n = $urandom_range(0, 5);
                    rx_q.push_back(8'hB5);
                    rx_q.push_back(8'(n));
                end else if (kind == 2) begin
                    rx_q.push_back(8'hC5);
                    exp_q.push_back({ov, 1'b0, tmo, 5'b0});
                    ov = 1'b0;
                    tmo = 1'b0;
                end else begin
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'hA5 || b == 8'hB5 || b == 8'hC5);
                    rx_q.push_back(b);
                    exp_err++;
                end
                if (kind < 2) begin
                    x = 8'h00;
                    for (int k = 0; k < n; k++) begin
                        w = 8'($urandom_range(0, 255));
                        fifo_q.push_back(w);
                        exp_q.push_back(w);
                        x ^= w;
                    end
                    exp_pops += n;
                    if (CHK) exp_q.push_back(x);
                end
            end
            drive();
            run_idle(30000);
            compare_tx("rand_tx", exp_q);
            check("rand_cmd_err_cycles", err_cyc, exp_err);
            check("rand_fifo_pops", pops, exp_pops);
            check("rand_fifo_left", fifo_q.size(), 0);
            fifo_rand = 1'b0;
            rx_rand   = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
